// File: rtl/bp_pc_sample_pkg.sv
// Shared types and helpers for the periodic committed-PC sampler.
// Slot states, the sample record and the round-robin wrap helper live here.
package bp_pc_sample_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_armed = 2'd1,
    e_full  = 2'd2
  } bp_pc_sample_state_e;

  localparam int pc_max_width_lp     = 64;
  localparam int hartid_max_width_lp = 8;

  typedef struct packed {
    logic [pc_max_width_lp-1:0]     pc;
    logic [hartid_max_width_lp-1:0] hartid;
  } bp_pc_sample_s;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bp_pc_sample_arbiter_if.sv
// Sample port from the arbiter toward the profile buffer (valid/ready).
interface bp_pc_sample_arbiter_if #(
  parameter int vaddr_width_p  = 39,
  parameter int hartid_width_p = 1
);
  logic                      sample_v_o;
  logic                      sample_ready_i;
  logic [vaddr_width_p-1:0]  sample_pc_o;
  logic [hartid_width_p-1:0] sample_hartid_o;

  modport master (
    output sample_v_o,
    output sample_pc_o,
    output sample_hartid_o,
    input  sample_ready_i
  );

  modport slave (
    input  sample_v_o,
    input  sample_pc_o,
    input  sample_hartid_o,
    output sample_ready_i
  );
endinterface

// File: rtl/bp_pc_sample_slot.sv
// One per-core capture slot: IDLE/ARMED/FULL FSM plus the captured PC.
// full_o reports the state after the coming edge so the arbiter can lock it then.
module bp_pc_sample_slot
  import bp_pc_sample_pkg::*;
#(
  parameter int vaddr_width_p = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     tick_i,
  input  logic                     freeze_i,
  input  logic                     commit_v_i,
  input  logic [vaddr_width_p-1:0] commit_pc_i,
  input  logic                     deq_i,
  output logic                     full_o,
  output logic [vaddr_width_p-1:0] pc_o,
  output logic                     drop_o
);

  bp_pc_sample_state_e      state_q, state_d;
  logic [vaddr_width_p-1:0] pc_q, pc_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      e_idle: begin
        if (!freeze_i && tick_i) begin
          state_d = commit_v_i ? e_full : e_armed;
        end
      end
      e_armed: begin
        if (freeze_i) begin
          state_d = e_idle;
        end else if (commit_v_i) begin
          state_d = e_full;
        end
      end
      e_full: begin
        // A tick coinciding with the drain re-arms instead of being lost
        if (deq_i) begin
          state_d = tick_i ? e_armed : e_idle;
        end
      end
      default: state_d = e_idle;
    endcase
    if (state_d == e_full && state_q != e_full) begin
      pc_d = commit_pc_i;
    end
  end

  assign full_o = (state_d == e_full);
  assign pc_o   = pc_q;
  assign drop_o = (state_q == e_full) && tick_i && !deq_i;

endmodule

// File: rtl/bp_pc_sample_arbiter.sv
// Interval timer, per-core capture slots, round-robin registered grant lock
// and saturating drop counter feeding a single valid/ready sample port.
module bp_pc_sample_arbiter
  import bp_pc_sample_pkg::*;
#(
  parameter int num_core_p       = 2,
  parameter int vaddr_width_p    = 39,
  parameter int interval_width_p = 16,
  parameter int drop_width_p     = 16,
  localparam int hartid_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                freeze_i,
  input  logic [interval_width_p-1:0]         interval_i,
  input  logic [num_core_p-1:0]               commit_v_i,
  input  logic [num_core_p*vaddr_width_p-1:0] commit_pc_i,
  bp_pc_sample_arbiter_if.master              sample_if,
  output logic [drop_width_p-1:0]             drop_count_o
);

  logic [interval_width_p-1:0] cnt_q, cnt_d;
  logic                        tick;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (freeze_i || interval_i == '0) begin
      cnt_d = '0;
    end else if (cnt_q >= interval_i - interval_width_p'(1)) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + interval_width_p'(1);
    end
  end

  logic                       lock_q, lock_d;
  logic [hartid_width_lp-1:0] grant_q, grant_d;
  logic [hartid_width_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic                       handshake;
  logic [num_core_p-1:0]      deq, full_next, drop;
  logic [vaddr_width_p-1:0]   slot_pc [num_core_p];

  assign handshake = lock_q && sample_if.sample_ready_i;

  for (genvar gi = 0; gi < num_core_p; gi++) begin : g_slot
    assign deq[gi] = handshake && (grant_q == hartid_width_lp'(gi));

    bp_pc_sample_slot #(
      .vaddr_width_p(vaddr_width_p)
    ) slot (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .tick_i     (tick),
      .freeze_i   (freeze_i),
      .commit_v_i (commit_v_i[gi]),
      .commit_pc_i(commit_pc_i[gi*vaddr_width_p +: vaddr_width_p]),
      .deq_i      (deq[gi]),
      .full_o     (full_next[gi]),
      .pc_o       (slot_pc[gi]),
      .drop_o     (drop[gi])
    );
  end

  int                         search_sum;
  logic [hartid_width_lp-1:0] search_idx;

  // Searching the post-edge full vector lets a fresh capture or the next
  // pending slot lock in the same edge as an accept.
  always_comb begin
    lock_d     = lock_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    search_sum = 0;
    search_idx = '0;
    if (handshake) begin
      rr_ptr_d = hartid_width_lp'(rr_next(int'(grant_q), num_core_p));
    end
    if (!lock_q || handshake) begin
      lock_d = 1'b0;
      for (int off = 0; off < num_core_p; off++) begin
        search_sum = int'(rr_ptr_d) + off;
        if (search_sum >= num_core_p) begin
          search_sum = search_sum - num_core_p;
        end
        search_idx = hartid_width_lp'(search_sum);
        if (!lock_d && full_next[search_idx]) begin
          lock_d  = 1'b1;
          grant_d = search_idx;
        end
      end
    end
  end

  logic [drop_width_p-1:0] drop_q, drop_d;
  logic [drop_width_p+7:0] drop_sum;

  always_comb begin
    drop_sum = {8'b0, drop_q};
    for (int i = 0; i < num_core_p; i++) begin
      drop_sum = drop_sum + (drop_width_p+8)'(drop[i]);
    end
    if (drop_sum > {8'b0, {drop_width_p{1'b1}}}) begin
      drop_d = '1;
    end else begin
      drop_d = drop_sum[drop_width_p-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      lock_q   <= 1'b0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      lock_q   <= lock_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= drop_d;
    end
  end

  assign sample_if.sample_v_o      = lock_q;
  assign sample_if.sample_pc_o     = slot_pc[grant_q];
  assign sample_if.sample_hartid_o = grant_q;
  assign drop_count_o              = drop_q;

endmodule

// File: tb/tb_bp_pc_sample_arbiter.sv
// Randomized and directed bench for bp_pc_sample_arbiter against a behavioural
// model; a second instance with a 2-bit drop counter covers saturation.
module tb_bp_pc_sample_arbiter;
  localparam int N  = 2;
  localparam int VA = 39;
  localparam int IW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            freeze;
  logic [IW-1:0]   interval;
  logic [N-1:0]    cv;
  logic [N*VA-1:0] cpc;
  logic            ready;
  logic [15:0]     drop;
  logic [1:0]      drop_s;

  bp_pc_sample_arbiter_if #(.vaddr_width_p(VA), .hartid_width_p(1)) sif ();
  bp_pc_sample_arbiter_if #(.vaddr_width_p(VA), .hartid_width_p(1)) sif_s ();
  assign sif.sample_ready_i   = ready;
  assign sif_s.sample_ready_i = ready;

  bp_pc_sample_arbiter #(.num_core_p(N), .vaddr_width_p(VA), .interval_width_p(IW), .drop_width_p(16)) dut (
    .clk_i(clk), .reset_i(rst), .freeze_i(freeze), .interval_i(interval),
    .commit_v_i(cv), .commit_pc_i(cpc), .sample_if(sif), .drop_count_o(drop));

  bp_pc_sample_arbiter #(.num_core_p(N), .vaddr_width_p(VA), .interval_width_p(IW), .drop_width_p(2)) dut_sat (
    .clk_i(clk), .reset_i(rst), .freeze_i(freeze), .interval_i(interval),
    .commit_v_i(cv), .commit_pc_i(cpc), .sample_if(sif_s), .drop_count_o(drop_s));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: per-core pending sample, arm flag, timer count, grant.
  bit          m_full [N];
  bit          m_armed[N];
  logic [VA-1:0] m_pc [N];
  int          m_cnt, m_grant, m_rr, m_drop, m_drop_s;

  logic [VA-1:0] acc_pc[$];
  int            acc_hart[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_armed[i] = 0; m_pc[i] = '0;
    end
    m_cnt = 0; m_grant = -1; m_rr = 0; m_drop = 0; m_drop_s = 0;
  endtask

  task automatic model_step();
    bit tick, hs;
    tick = !freeze && interval != 0 && (m_cnt >= int'(interval) - 1);
    hs   = (m_grant >= 0) && ready;
    for (int i = 0; i < N; i++) begin
      if (m_full[i]) begin
        if (hs && m_grant == i) begin
          m_full[i] = 0; m_armed[i] = tick;
        end else if (tick) begin
          if (m_drop < 65535) m_drop++;
          if (m_drop_s < 3) m_drop_s++;
        end
      end else if (freeze) begin
        m_armed[i] = 0;
      end else if ((m_armed[i] || tick) && cv[i]) begin
        m_full[i] = 1; m_armed[i] = 0; m_pc[i] = cpc[i*VA +: VA];
      end else begin
        m_armed[i] = m_armed[i] || tick;
      end
    end
    if (freeze || interval == 0 || tick) m_cnt = 0;
    else m_cnt++;
    if (hs) m_rr = (m_grant + 1) % N;
    if (hs || m_grant < 0) begin
      m_grant = -1;
      for (int off = 0; off < N; off++) begin
        if (m_grant < 0 && m_full[(m_rr + off) % N]) m_grant = (m_rr + off) % N;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("valid", sif.sample_v_o, m_grant >= 0);
    check_eq("drop", drop, m_drop);
    check_eq("drop_sat", drop_s, m_drop_s);
    if (m_grant >= 0) begin
      check_eq("hartid", sif.sample_hartid_o, m_grant);
      check_eq("pc", sif.sample_pc_o, m_pc[m_grant]);
    end
  endtask

  task automatic cycle();
    if (sif.sample_v_o && ready) begin
      acc_pc.push_back(sif.sample_pc_o);
      acc_hart.push_back(int'(sif.sample_hartid_o));
      $display("accept hart %0d pc 0x%0h drops %0d", sif.sample_hartid_o, sif.sample_pc_o, drop);
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous pulse between edges; outputs must clear without a clock.
  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_valid", sif.sample_v_o, 0);
    check_eq("rst_drop", drop, 0);
    check_eq("rst_drop_sat", drop_s, 0);
    rst = 1'b0;
    model_reset();
    acc_pc.delete();
    acc_hart.delete();
  endtask

  task automatic set_idle_inputs();
    freeze = 0; cv = '0; cpc = '0; ready = 0;
  endtask

  initial begin
    rst = 1'b1; interval = '0;
    set_idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("init_valid", sif.sample_v_o, 0);
    check_eq("init_pc", sif.sample_pc_o, 0);
    check_eq("init_hartid", sif.sample_hartid_o, 0);
    check_eq("init_drop", drop, 0);
    rst = 1'b0;

    // Core0 commits sequential PCs every cycle, one sample per 4-cycle interval
    interval = 4; ready = 1; cv = 2'b01;
    for (int k = 0; k < 40; k++) begin
      cpc[0 +: VA] = VA'(64'h8000_0000 + 4 * k);
      cycle();
    end
    check_eq("p1_drop", drop, 0);
    check_eq("p1_count", acc_pc.size(), 9);
    for (int k = 1; k < acc_pc.size(); k++) begin
      check_eq("p1_step", acc_pc[k] - acc_pc[k-1], 'h10);
      check_eq("p1_hart", acc_hart[k], 0);
    end

    // Both cores stalled behind a blocked sink
    set_idle_inputs(); reset_pulse();
    interval = 2; cv = 2'b11;
    for (int k = 0; k < 20; k++) begin
      cpc = {VA'({$urandom, $urandom}), VA'({$urandom, $urandom})};
      cycle();
    end
    check_eq("p2_drop", drop, 18);
    check_eq("p2_drop_sat", drop_s, 3);
    cv = '0; ready = 1;
    repeat (4) cycle();
    check_eq("p2_count", acc_hart.size(), 2);
    if (acc_hart.size() == 2) begin
      check_eq("p2_first", acc_hart[0], 0);
      check_eq("p2_second", acc_hart[1], 1);
    end

    // Core1 armed for a long time before its single commit
    set_idle_inputs(); reset_pulse();
    interval = 3; ready = 1;
    repeat (10) cycle();
    cv = 2'b10; cpc[VA +: VA] = VA'(64'h1234);
    cycle();
    cv = '0;
    repeat (8) cycle();
    check_eq("p3_count", acc_hart.size(), 1);
    if (acc_hart.size() == 1) begin
      check_eq("p3_hart", acc_hart[0], 1);
      check_eq("p3_pc", acc_pc[0], 'h1234);
    end
    check_eq("p3_drop", drop, 0);

    // Freeze with core0 armed and core1 full
    set_idle_inputs(); reset_pulse();
    interval = 2;
    repeat (2) cycle();
    cv = 2'b10; cpc[VA +: VA] = VA'(64'h5550);
    cycle();
    freeze = 1; cv = 2'b11; cpc[0 +: VA] = VA'(64'h7770);
    for (int k = 0; k < 6; k++) begin
      ready = (k >= 2);
      cycle();
    end
    check_eq("p4_count", acc_hart.size(), 1);
    if (acc_hart.size() == 1) check_eq("p4_hart", acc_hart[0], 1);
    freeze = 0; cv = 2'b01;
    repeat (4) cycle();

    // Async reset while a sample is pending, then a fresh interval
    set_idle_inputs(); reset_pulse();
    interval = 1; cv = 2'b11;
    repeat (4) cycle();
    check_eq("p5_pending", sif.sample_v_o, 1);
    reset_pulse();
    interval = 4; cv = 2'b01; ready = 1;
    repeat (6) cycle();

    // Interval lowered below the running count
    set_idle_inputs(); reset_pulse();
    interval = 8;
    repeat (6) cycle();
    interval = 2; cv = 2'b01; cpc[0 +: VA] = VA'(64'hABC0); ready = 1;
    cycle();
    check_eq("p6_valid", sif.sample_v_o, 1);
    check_eq("p6_pc", sif.sample_pc_o, 'hABC0);
    cv = '0;
    repeat (3) cycle();

    // Randomized traffic
    set_idle_inputs(); reset_pulse();
    for (int k = 0; k < 600; k++) begin
      if (k % 16 == 0) interval = IW'($urandom_range(0, 5));
      freeze = ($urandom_range(0, 15) == 0);
      cv     = N'($urandom);
      ready  = $urandom_range(0, 1) == 1;
      cpc    = {VA'({$urandom, $urandom}), VA'({$urandom, $urandom})};
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
